hsi_result_drain: RTL and testbench
===================================

// Module: hsi_result_drain
// PURPOSE
//   Drain side of the HSI vector core output FIFO: pops packed result vectors and serialises them,
//   one component per beat, onto a valid/ready stream toward the host/DMA. Component count follows op_code:
//   OP_CROSS (0) emits 3 components, OP_DOT (1) emits 1 (result[0]). Counts drained pixels, flags config errors.
// PARAMETERS
//   COMPONENT_WIDTH  16  bits per H/S/I component (stream beat width)
//   COMPONENTS_MAX   3   components packed per FIFO word; word width = COMPONENT_WIDTH*COMPONENTS_MAX
// PORTS
//   clk          in   1     clock; all logic on rising edge
//   rst_n        in   1     asynchronous, active-low reset
//   enable       in   1     level; allows new vector fetches
//   clear        in   1     sync pulse: pixel_count<=0, error_code<=0, ERROR->IDLE
//   op_code      in   4     0=OP_CROSS, 1=OP_DOT; sampled at fetch
//   num_bands    in   32    must be 3 for OP_CROSS, 1..COMPONENTS_MAX for OP_DOT
//   fifo_empty   in   1     output-FIFO empty flag
//   fifo_rd_en   out  1     combinational pop request, one cycle per vector
//   fifo_data    in   CW*CM FIFO read data, valid the cycle after fifo_rd_en
//   m_valid      out  1     stream beat valid
//   m_ready      in   1     stream sink ready
//   m_data       out  CW    component; component 0 = fifo_data[CW-1:0] first
//   m_last       out  1     high on final beat of a vector
//   pixel_count  out  32    vectors fully sent (m_last handshakes), wraps 0xFFFFFFFF->0
//   busy         out  1     state != IDLE && state != ERROR
//   error_code   out  4     0=OK, 1=ERR_OP, 4=ERR_BANDS; sticky until clear/reset
// BEHAVIOUR
//   Reset: state=IDLE; fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, pixel_count=0, busy=0, error_code=0.
//   cfg_ok = (op_code==0 && num_bands==3) || (op_code==1 && num_bands>=1 && num_bands<=COMPONENTS_MAX).
//   States IDLE, LOAD, SEND, ERROR.
//   IDLE: if enable && !cfg_ok -> ERROR, error_code = (num_bands>COMPONENTS_MAX)?4:1; no pop.
//         elif enable && !fifo_empty -> fifo_rd_en=1 this cycle, latch op_code into n_beats (3 or 1), -> LOAD.
//   LOAD: capture fifo_data into hold register, idx<=0, -> SEND. m_valid=0 here.
//   SEND: m_valid=1, m_data=hold[idx], m_last=(idx==n_beats-1). Beat transfers when m_valid&&m_ready.
//         Non-last transfer: idx++. Last transfer: pixel_count++; if enable && cfg_ok && !fifo_empty
//         then fifo_rd_en=1 same cycle -> LOAD, else -> IDLE.
//   ERROR: no pops, m_valid=0; leaves only via clear (-> IDLE) or reset. clear also wins in any state for
//         pixel_count/error_code but does not abort SEND.
//   Stability: while m_valid && !m_ready, m_data/m_last held constant; m_valid never drops without transfer.
//   enable deasserted mid-vector: current vector completes; only further fetches are blocked.
//   op_code/num_bands changes after fetch do not affect the vector in flight.
//   fifo_rd_en never asserted when fifo_empty=1; exactly one pop per vector; no data loss on backpressure.
//   Throughput: N beats per vector + 1 LOAD bubble; latency fifo_rd_en -> first m_valid = 2 cycles.
//   Reset mid-SEND: beat abandoned immediately, all outputs return to reset values, popped vector lost.
// TESTING
//   CROSS: op=0,bands=3, FIFO word {16'h0003,16'h0002,16'h0001}, m_ready=1 -> beats 1,2,3; m_last on 3rd; count=1.
//   DOT: op=1,bands=2, words 0x0000_0000_0064 then 0x...0007 -> beats 100(last),7(last); 2 pops; count=2.
//   Backpressure: CROSS, m_ready toggles 1,0,0,1,0,1 -> m_data stable while stalled, exactly 3 beats, no extra pop.
//   Empty/enable: fifo_empty=1, enable=1 for 20 cycles -> fifo_rd_en=0, m_valid=0, busy=0; enable=0 mid-vector -> vector finishes.
//   Errors: op=0,bands=2 -> error_code=1, ERROR, no pops; bands=5 -> error_code=4; clear pulse -> IDLE, code=0, count=0.
//   Reset mid-SEND after beat 1 -> next cycle m_valid=0, busy=0, pixel_count=0; fresh vector then drains correctly.

Source files
------------

// File: rtl/hsi_result_drain_if.sv
// Result-drain bus: output-FIFO read side plus the outbound component stream.
interface hsi_result_drain_if #(
  parameter int COMPONENT_WIDTH = 16,
  parameter int COMPONENTS_MAX  = 3
);
  logic                                      fifo_empty;
  logic                                      fifo_rd_en;
  logic [COMPONENT_WIDTH*COMPONENTS_MAX-1:0] fifo_data;
  logic                                      m_valid;
  logic                                      m_ready;
  logic [COMPONENT_WIDTH-1:0]                m_data;
  logic                                      m_last;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/hsi_result_drain.sv
// Pops packed H/S/I result vectors from the output FIFO and streams them one
// component per beat; counts completed vectors and latches config errors.
module hsi_result_drain #(
  parameter int COMPONENT_WIDTH = 16,
  parameter int COMPONENTS_MAX  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [3:0]           op_code,
  input  logic [31:0]          num_bands,
  hsi_result_drain_if.master   bus,
  output logic [31:0]          pixel_count,
  output logic                 busy,
  output logic [3:0]           error_code
);
  localparam int WW = COMPONENT_WIDTH * COMPONENTS_MAX;
  localparam int IW = (COMPONENTS_MAX > 1) ? $clog2(COMPONENTS_MAX) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, ERROR} state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   hold_q, hold_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   last_idx_q, last_idx_d;
  logic [31:0]     pixel_count_q, pixel_count_d;
  logic [3:0]      error_code_q, error_code_d;
  logic            cfg_ok;
  logic            fetch_ok;
  logic            beat_last;
  logic [IW-1:0]   fetch_last_idx;

  always_comb begin
    cfg_ok = ((op_code == 4'd0) && (num_bands == 32'd3)) ||
             ((op_code == 4'd1) && (num_bands >= 32'd1) &&
              (num_bands <= 32'(COMPONENTS_MAX)));
    fetch_ok       = enable && cfg_ok && !bus.fifo_empty;
    fetch_last_idx = (op_code == 4'd0) ? IW'(2) : '0;
    beat_last      = (idx_q == last_idx_q);
  end

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    idx_d          = idx_q;
    last_idx_d     = last_idx_q;
    pixel_count_d  = pixel_count_q;
    error_code_d   = error_code_q;
    bus.fifo_rd_en = 1'b0;
    bus.m_valid    = 1'b0;
    bus.m_data     = '0;
    bus.m_last     = 1'b0;

    case (state_q)
      IDLE: begin
        // A concurrent clear suppresses error entry so the code it zeroes is not re-set.
        if (enable && !cfg_ok) begin
          if (!clear) begin
            state_d      = ERROR;
            error_code_d = (num_bands > 32'(COMPONENTS_MAX)) ? 4'd4 : 4'd1;
          end
        end else if (fetch_ok) begin
          bus.fifo_rd_en = 1'b1;
          last_idx_d     = fetch_last_idx;
          state_d        = LOAD;
        end
      end
      LOAD: begin
        hold_d  = bus.fifo_data;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        bus.m_valid = 1'b1;
        bus.m_last  = beat_last;
        for (int unsigned i = 0; i < COMPONENTS_MAX; i++) begin
          if (idx_q == IW'(i)) bus.m_data = hold_q[i*COMPONENT_WIDTH +: COMPONENT_WIDTH];
        end
        if (bus.m_ready) begin
          if (!beat_last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            pixel_count_d = pixel_count_q + 32'd1;
            if (fetch_ok) begin
              bus.fifo_rd_en = 1'b1;
              last_idx_d     = fetch_last_idx;
              state_d        = LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      ERROR: begin
        if (clear) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      pixel_count_d = '0;
      error_code_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      idx_q         <= '0;
      last_idx_q    <= '0;
      pixel_count_q <= '0;
      error_code_q  <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      idx_q         <= idx_d;
      last_idx_q    <= last_idx_d;
      pixel_count_q <= pixel_count_d;
      error_code_q  <= error_code_d;
    end
  end

  assign pixel_count = pixel_count_q;
  assign error_code  = error_code_q;
  assign busy        = (state_q == LOAD) || (state_q == SEND);
endmodule

// File: tb/tb_hsi_result_drain.sv
// Scoreboard bench for hsi_result_drain: FIFO model plus expected-beat queue.
module tb_hsi_result_drain;
  localparam int CW = 16;
  localparam int CM = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [3:0]  op_code;
  logic [31:0] num_bands;
  logic [31:0] pixel_count;
  logic        busy;
  logic [3:0]  error_code;

  hsi_result_drain_if #(.COMPONENT_WIDTH(CW), .COMPONENTS_MAX(CM)) bus ();

  hsi_result_drain #(.COMPONENT_WIDTH(CW), .COMPONENTS_MAX(CM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clear       (clear),
    .op_code     (op_code),
    .num_bands   (num_bands),
    .bus         (bus),
    .pixel_count (pixel_count),
    .busy        (busy),
    .error_code  (error_code)
  );

  always #5 clk = ~clk;

  logic [CW*CM-1:0] fifo_q[$];
  logic [CW:0]      exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int pops = 0;
  int cyc = 0;
  int hs_count = 0;
  int exp_count = 0;
  int last_rd_cyc = -1;
  int last_hs_cyc = -1;
  int valid_rise_cyc = -1;
  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [CW:0] prev_beat = '0;

  // One clock: sample at negedge+1, apply FIFO pop and score beats after posedge.
  task automatic step();
    logic rd, hs;
    logic [CW:0] beat, exp;
    #1;
    rd   = bus.fifo_rd_en;
    hs   = bus.m_valid && bus.m_ready;
    beat = {bus.m_last, bus.m_data};
    if (prev_stall) begin
      n_cmp++;
      if (bus.m_valid !== 1'b1 || beat !== prev_beat) begin
        n_err++;
        $display("FAIL stall_hold: valid=%b beat=%h required valid=1 beat=%h", bus.m_valid, beat, prev_beat);
      end
    end
    if (bus.m_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = bus.m_valid;
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_beat  = beat;
    if (rd) begin
      n_cmp++;
      last_rd_cyc = cyc;
      if (fifo_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_when_empty: fifo_rd_en=1 required 0 (fifo empty)");
      end
    end
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) begin
      bus.fifo_data = fifo_q.pop_front();
      pops++;
    end
    bus.fifo_empty = (fifo_q.size() == 0);
    if (hs) begin
      n_cmp++;
      hs_count++;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got last/data=%h required none", beat);
      end else begin
        exp = exp_q.pop_front();
        if (beat !== exp) begin
          n_err++;
          $display("FAIL beat_data: got last/data=%h required %h", beat, exp);
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic push_word(input logic [3:0] op, input logic [CW*CM-1:0] word);
    int nb;
    fifo_q.push_back(word);
    bus.fifo_empty = 1'b0;
    nb = (op == 4'd0) ? 3 : 1;
    for (int i = 0; i < nb; i++) exp_q.push_back({(i == nb - 1), word[i*CW +: CW]});
    exp_count++;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (exp_q.size() == 0 && fifo_q.size() == 0 && busy === 1'b0) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: %0d beats outstanding required 0", name, exp_q.size());
    end
  endtask

  task automatic check_count(input string name);
    n_cmp++;
    if (pixel_count !== 32'(exp_count)) begin
      n_err++;
      $display("FAIL %s_count: pixel_count=%0d required %0d", name, pixel_count, exp_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; op_code = 4'd0; num_bands = 32'd3;
    bus.fifo_empty = 1'b1; bus.fifo_data = '0; bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.fifo_rd_en, bus.m_valid, bus.m_data, bus.m_last, pixel_count, busy, error_code} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rd=%b v=%b d=%h l=%b cnt=%0d busy=%b err=%0d required all 0",
               bus.fifo_rd_en, bus.m_valid, bus.m_data, bus.m_last, pixel_count, busy, error_code);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cross();
    int p0 = pops;
    enable = 1'b1; op_code = 4'd0; num_bands = 32'd3; bus.m_ready = 1'b1;
    push_word(4'd0, 48'h0003_0002_0001);
    drain("cross");
    check_count("cross");
    n_cmp++;
    if (pops - p0 !== 1) begin
      n_err++;
      $display("FAIL cross_pops: pops=%0d required 1", pops - p0);
    end
  endtask

  task automatic test_dot();
    int p0 = pops;
    op_code = 4'd1; num_bands = 32'd2;
    push_word(4'd1, 48'h0000_0000_0064);
    push_word(4'd1, 48'h0000_0000_0007);
    drain("dot");
    check_count("dot");
    n_cmp++;
    if (pops - p0 !== 2) begin
      n_err++;
      $display("FAIL dot_pops: pops=%0d required 2", pops - p0);
    end
  endtask

  task automatic test_back_to_back();
    int t0, got, prev_hs, h0;
    op_code = 4'd1; num_bands = 32'd1; bus.m_ready = 1'b1;
    push_word(4'd1, 48'h0011);
    push_word(4'd1, 48'h0022);
    push_word(4'd1, 48'h0033);
    t0 = cyc;
    step();
    n_cmp++;
    if (last_rd_cyc !== t0) begin
      n_err++;
      $display("FAIL b2b_first_pop: pop cycle=%0d required %0d", last_rd_cyc, t0);
    end
    got = 0;
    prev_hs = 0;
    for (int i = 0; i < 50 && got < 3; i++) begin
      h0 = hs_count;
      step();
      if (hs_count != h0) begin
        n_cmp++;
        if (got == 0 && valid_rise_cyc - t0 !== 2) begin
          n_err++;
          $display("FAIL b2b_latency: %0d cycles required 2", valid_rise_cyc - t0);
        end else if (got > 0 && last_hs_cyc - prev_hs !== 2) begin
          n_err++;
          $display("FAIL b2b_spacing: %0d cycles required 2", last_hs_cyc - prev_hs);
        end
        prev_hs = last_hs_cyc;
        got++;
      end
    end
    drain("b2b");
    check_count("b2b");
  endtask

  task automatic test_backpressure();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int p0 = pops;
    int h0 = hs_count;
    op_code = 4'd0; num_bands = 32'd3; bus.m_ready = 1'b0;
    push_word(4'd0, 48'hBEEF_C0DE_0A5A);
    for (int i = 0; i < 20 && bus.m_valid !== 1'b1; i++) step();
    for (int i = 0; i < 6; i++) begin
      bus.m_ready = pat[i];
      step();
    end
    n_cmp++;
    if (hs_count - h0 !== 3) begin
      n_err++;
      $display("FAIL bp_beats: beats=%0d required 3", hs_count - h0);
    end
    bus.m_ready = 1'b1;
    drain("bp");
    check_count("bp");
    n_cmp++;
    if (pops - p0 !== 1) begin
      n_err++;
      $display("FAIL bp_pops: pops=%0d required 1", pops - p0);
    end
  endtask

  task automatic test_empty_enable();
    int p0, h0;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      #1;
      n_cmp++;
      if ({bus.fifo_rd_en, bus.m_valid, busy} !== 3'b000) begin
        n_err++;
        $display("FAIL empty_idle: rd/valid/busy=%b required 000", {bus.fifo_rd_en, bus.m_valid, busy});
      end
    end
    p0 = pops;
    h0 = hs_count;
    push_word(4'd0, 48'h0303_0202_0101);
    push_word(4'd0, 48'h0606_0505_0404);
    for (int i = 0; i < 20 && hs_count == h0; i++) step();
    enable = 1'b0;
    repeat (12) step();
    n_cmp++;
    if (pops - p0 !== 1 || exp_q.size() !== 3 || pixel_count !== 32'(exp_count - 1)) begin
      n_err++;
      $display("FAIL enable_mid_vector: pops=%0d left=%0d cnt=%0d required pops=1 left=3 cnt=%0d",
               pops - p0, exp_q.size(), pixel_count, exp_count - 1);
    end
    enable = 1'b1;
    drain("enable");
    check_count("enable");
  endtask

  task automatic test_errors();
    int p0 = pops;
    enable = 1'b1; op_code = 4'd0; num_bands = 32'd2;
    push_word(4'd0, 48'h0C0C_0B0B_0A0A);
    repeat (4) step();
    n_cmp++;
    if (error_code !== 4'd1 || busy !== 1'b0 || bus.m_valid !== 1'b0 || pops !== p0) begin
      n_err++;
      $display("FAIL err_op: code=%0d busy=%b valid=%b pops=%0d required code=1 busy=0 valid=0 pops=0",
               error_code, busy, bus.m_valid, pops - p0);
    end
    op_code = 4'd1; num_bands = 32'd5;
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (error_code !== 4'd4 || pops !== p0) begin
      n_err++;
      $display("FAIL err_bands: code=%0d pops=%0d required code=4 pops=0", error_code, pops - p0);
    end
    op_code = 4'd0; num_bands = 32'd3;
    clear = 1'b1;
    step();
    clear = 1'b0;
    // Count restarts at zero; only the still-queued word will be counted.
    exp_count = 0;
    check_count("clear");
    n_cmp++;
    if (error_code !== 4'd0 || pops !== p0) begin
      n_err++;
      $display("FAIL clear_code: code=%0d pops=%0d required code=0 pops=0", error_code, pops - p0);
    end
    exp_count = 1;
    drain("after_clear");
    check_count("after_clear");
  endtask

  task automatic test_reset_mid_send();
    int h0 = hs_count;
    enable = 1'b1; op_code = 4'd0; num_bands = 32'd3; bus.m_ready = 1'b1;
    push_word(4'd0, 48'h0F0F_0E0E_0D0D);
    for (int i = 0; i < 20 && hs_count == h0; i++) step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.m_valid, busy, bus.m_last, bus.m_data, pixel_count} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_send: valid=%b busy=%b last=%b data=%h cnt=%0d required all 0",
               bus.m_valid, busy, bus.m_last, bus.m_data, pixel_count);
    end
    exp_q.delete();
    exp_count = 0;
    prev_stall = 1'b0;
    prev_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_word(4'd0, 48'h0009_0008_0007);
    drain("post_reset");
    check_count("post_reset");
  endtask

  initial begin
    test_reset();
    test_cross();
    test_dot();
    test_back_to_back();
    test_backpressure();
    test_empty_enable();
    test_errors();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
